// File: rtl/apple1_char_sender_if.sv
// Apple-1 display port bundle: character source side plus
// the rd/da/rda_n handshake toward video_terminal.
interface apple1_char_sender_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [6:0]    wr_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic [7:1]    rd;
  logic          da;
  logic          rda_n;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;

  modport master (
    output wr_en,
    output wr_data,
    output rda_n,
    output err_clr,
    input  full,
    input  empty,
    input  level,
    input  rd,
    input  da,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rda_n,
    input  err_clr,
    output full,
    output empty,
    output level,
    output rd,
    output da,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/apple1_char_sender.sv
// Apple-1 display port transmitter: FIFO-buffered characters
// presented on rd with da, released on the terminal's rda_n ack.
module apple1_char_sender #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                 clk_in,
  input logic                 rst_n,
  apple1_char_sender_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);
  localparam logic [SW-1:0] S_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          sync1;
  logic          rda_s;

  logic [1:0]    state;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [7:1]    rd;
  logic          da;
  logic          err;
  logic          err_set;

  assign full  = (count == L_FULL);
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty && rda_s;
  // a full FIFO still takes a push when the head leaves that cycle
  assign push  = bus.wr_en && (!full || pop);

  assign err_set = (state == WAIT_ACK) && rda_s
                && (tcnt == T_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rda_s <= 1'b1;
    end else begin
      sync1 <= bus.rda_n;
      rda_s <= sync1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= '0;
      tcnt  <= '0;
      rd    <= '0;
      da    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            rd    <= mem[rptr];
            scnt  <= '0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (scnt == S_LAST) begin
            tcnt  <= '0;
            da    <= 1'b1;
            state <= WAIT_ACK;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (!rda_s) begin
            da    <= 1'b0;
            state <= WAIT_REL;
          end else if (tcnt != T_MAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (rda_s) begin
            state <= IDLE;
          end
        end
        default: begin
          da    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // a fresh timeout beats a clear landing in the same cycle
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (bus.err_clr) begin
      err <= 1'b0;
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.level       = count;
  assign bus.rd          = rd;
  assign bus.da          = da;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = err;
endmodule

// File: tb/tb_apple1_char_sender.sv
// Directed bench for apple1_char_sender: FIFO table plus
// handshake, burst, timeout, stuck-ack and reset sequences.
module tb_apple1_char_sender;
  localparam int DEPTH = 8;
  localparam int SETUP = 2;
  localparam int TMO   = 100;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  apple1_char_sender_if #(.FIFO_DEPTH(DEPTH)) bus ();

  apple1_char_sender #(
    .FIFO_DEPTH    (DEPTH),
    .SETUP_CYCLES  (SETUP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       wr;
    logic [6:0] d;
    logic       ack_n;
    logic       full;
    logic       empty;
    logic [3:0] lvl;
    logic       da;
    logic       busy;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  logic bs1, bs2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs1 <= 1'b1;
      bs2 <= 1'b1;
    end else begin
      bs1 <= bus.rda_n;
      bs2 <= bs1;
    end
  end

  logic       da_q = 1'b0;
  logic [7:1] rd_q = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.da && da_q)
        check("rd_stable", 32'(bus.rd), 32'(rd_q));
      if (bus.da && !da_q)
        check("da_rise_ack_high", 32'(bs2), 32'd1);
    end
    da_q = bus.da;
    rd_q = bus.rd;
  end

  task automatic write_char(input logic [6:0] c);
    bus.wr_en   = 1'b1;
    bus.wr_data = c;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_da(input string name);
    int n = 0;
    while (!bus.da && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.da) fail_now(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic get_char(input logic [6:0] exp,
                          input int dly,
                          input string name);
    wait_da({name, "_da"});
    if (!bus.da) return;
    check({name, "_rd"}, 32'(bus.rd), 32'(exp));
    repeat (dly) @(negedge clk);
    bus.rda_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({name, "_da_hold"}, 32'(bus.da), 32'd1);
    @(negedge clk);
    check({name, "_da_fall"}, 32'(bus.da), 32'd0);
    bus.rda_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 7'h41, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 7'h42, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 7'h43, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 7'h44, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 7'h45, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 7'h46, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 7'h47, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 7'h48, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 7'h5A, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rda_n   = 1'b1;
    bus.err_clr = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_da", 32'(bus.da), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.timeout_err), 32'd0);
    check("rst_fifo", 32'({bus.empty, bus.full, bus.level}),
          32'({1'b1, 1'b0, 4'd0}));
    rst_n = 1'b1;
    @(negedge clk);

    // single character, latency and handshake timing
    write_char(7'h41);
    check("t1_rd_n1", 32'(bus.rd), 32'd0);
    check("t1_lvl_n1", 32'(bus.level), 32'd1);
    @(negedge clk);
    check("t1_rd_n2", 32'(bus.rd), 32'h41);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_da_n2", 32'(bus.da), 32'd0);
    @(negedge clk);
    check("t1_da_n3", 32'(bus.da), 32'd0);
    @(negedge clk);
    check("t1_da_n4", 32'(bus.da), 32'd1);
    get_char(7'h41, 20, "t1");
    wait_idle("t1_idle");

    // burst of five with ack responder
    bus.wr_en = 1'b1;
    bus.wr_data = 7'h48;
    @(negedge clk);
    bus.wr_data = 7'h45;
    @(negedge clk);
    bus.wr_data = 7'h4C;
    @(negedge clk);
    bus.wr_data = 7'h4C;
    @(negedge clk);
    bus.wr_data = 7'h4F;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("burst_lvl", 32'(bus.level), 32'd4);
    get_char(7'h48, 3, "burst0");
    get_char(7'h45, 3, "burst1");
    get_char(7'h4C, 3, "burst2");
    get_char(7'h4C, 3, "burst3");
    get_char(7'h4F, 3, "burst4");
    wait_idle("burst_idle");
    check("burst_empty", 32'({bus.empty, bus.level}),
          32'({1'b1, 4'd0}));

    // fill past full with acknowledge held low
    for (int k = 0; k < 13; k++) begin
      bus.wr_en   = tbl[k].wr;
      bus.wr_data = tbl[k].d;
      bus.rda_n   = tbl[k].ack_n;
      @(negedge clk);
      check($sformatf("tbl%0d", k),
            32'({bus.full, bus.empty, bus.level, bus.da, bus.busy}),
            32'({tbl[k].full, tbl[k].empty, tbl[k].lvl,
                 tbl[k].da, tbl[k].busy}));
    end
    bus.wr_en = 1'b0;
    bus.rda_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      get_char(7'(8'h41 + k), 2, $sformatf("full%0d", k));
    end
    repeat (30) @(negedge clk);
    check("full_no_ninth",
          32'({bus.da, bus.busy, bus.empty}), 32'({1'b0, 1'b0, 1'b1}));

    // stuck-low acknowledge holds off the transfer
    bus.rda_n = 1'b0;
    repeat (4) @(negedge clk);
    write_char(7'h20);
    repeat (10) @(negedge clk);
    check("stuck_hold",
          32'({bus.da, bus.busy, bus.level}),
          32'({1'b0, 1'b0, 4'd1}));
    bus.rda_n = 1'b1;
    get_char(7'h20, 2, "stuck");
    wait_idle("stuck_idle");

    // timeout, clear racing the set, then clean completion
    write_char(7'h54);
    wait_da("tmo_da");
    repeat (TMO - 1) @(negedge clk);
    check("tmo_before", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("tmo_set_wins", 32'(bus.timeout_err), 32'd1);
    check("tmo_da_high", 32'(bus.da), 32'd1);
    @(negedge clk);
    check("tmo_sticky", 32'(bus.timeout_err), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("tmo_cleared", 32'(bus.timeout_err), 32'd0);
    get_char(7'h54, 3, "tmo");
    wait_idle("tmo_idle");
    check("tmo_err_after", 32'(bus.timeout_err), 32'd0);

    // asynchronous reset in the middle of a transfer
    write_char(7'h31);
    write_char(7'h32);
    write_char(7'h33);
    write_char(7'h34);
    wait_da("mid_da");
    repeat (TMO) @(negedge clk);
    check("mid_err_set", 32'(bus.timeout_err), 32'd1);
    check("mid_queued", 32'(bus.level), 32'd3);
    #5;
    rst_n = 1'b0;
    #1;
    check("mid_da", 32'(bus.da), 32'd0);
    check("mid_fifo", 32'({bus.empty, bus.level}),
          32'({1'b1, 4'd0}));
    check("mid_err", 32'(bus.timeout_err), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_char(7'h35);
    get_char(7'h35, 2, "post_rst");
    wait_idle("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
